// File: rtl/ctrl_unit_fsm.sv
// Three-cycle instruction control unit (FETCH/WAIT/EXEC) with an absorbing HALT.
// The control bus is decoded combinationally from the current state and opcode.
module ctrl_unit_fsm #(
  parameter int          SIGNALS_SIZE = 5,
  parameter logic [4:0]  HALT_OPCODE  = 5'b11111
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [4:0]              opcode,
  output logic [SIGNALS_SIZE-1:0] signals,
  output logic [1:0]              state,
  output logic                    halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [4:0] SIG_FETCH = 5'b00011;
  localparam logic [4:0] SIG_ALU   = 5'b10100;
  localparam logic [4:0] SIG_LDI   = 5'b01100;
  localparam logic [4:0] SIG_CMP   = 5'b10000;

  state_t     state_q, state_d;
  logic [4:0] ctrl;

  // Opcode only matters in EXEC: the code memory read is not valid earlier.
  always_comb begin
    state_d = state_q;
    if (run) begin
      unique case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_EXEC;
        ST_EXEC:  state_d = (opcode == HALT_OPCODE) ? ST_HALT : ST_FETCH;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // A stalled or resetting machine must never assert a write strobe.
  always_comb begin
    ctrl = 5'b00000;
    if (rst_n && run) begin
      unique case (state_q)
        ST_FETCH: ctrl = SIG_FETCH;
        ST_EXEC: begin
          if (opcode == HALT_OPCODE)      ctrl = 5'b00000;
          else if (opcode[4:3] == 2'b00)  ctrl = SIG_ALU;
          else if (opcode == 5'b01000)    ctrl = SIG_LDI;
          else if (opcode == 5'b01001)    ctrl = SIG_CMP;
          else                            ctrl = 5'b00000;
        end
        default:  ctrl = 5'b00000;
      endcase
    end
  end

  always_comb begin
    signals      = '0;
    signals[4:0] = ctrl;
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Directed-vector bench for ctrl_unit_fsm with hand-computed expected values.
module tb_ctrl_unit_fsm;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [4:0] opcode;
  logic [4:0] signals;
  logic [1:0] state;
  logic       halted;

  int n_vec;
  int n_err;

  ctrl_unit_fsm #(.SIGNALS_SIZE(5), .HALT_OPCODE(5'b11111)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .opcode  (opcode),
    .signals (signals),
    .state   (state),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [1:0] st,
                            input logic [4:0] sig, input logic hlt);
    check({tag, ".state"},   {30'd0, state},   {30'd0, st});
    check({tag, ".signals"}, {27'd0, signals}, {27'd0, sig});
    check({tag, ".halted"},  {31'd0, halted},  {31'd0, hlt});
  endtask

  // Advance one rising edge; inputs change 1ns after it, checks follow a settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // From FETCH: walk to EXEC with a junk opcode in FETCH/WAIT, then present op.
  task automatic run_to_exec(input logic [4:0] op);
    opcode = 5'b11111;
    tick();
    opcode = 5'b11111;
    tick();
    opcode = op;
    settle();
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    run    = 1'b1;
    opcode = 5'b00000;

    tick();
    settle();
    expect_cyc("rst_hold", 2'b00, 5'h00, 1'b0);

    rst_n = 1'b1;
    settle();
    expect_cyc("seq_fetch", 2'b00, 5'h03, 1'b0);
    tick(); settle();
    expect_cyc("seq_wait", 2'b01, 5'h00, 1'b0);
    tick(); settle();
    expect_cyc("seq_exec_alu", 2'b10, 5'h14, 1'b0);
    tick(); settle();
    expect_cyc("seq_fetch2", 2'b00, 5'h03, 1'b0);

    run_to_exec(5'b01000);
    expect_cyc("exec_ldi", 2'b10, 5'h0C, 1'b0);
    tick(); settle();
    expect_cyc("after_ldi", 2'b00, 5'h03, 1'b0);

    run_to_exec(5'b01001);
    expect_cyc("exec_cmp", 2'b10, 5'h10, 1'b0);
    tick(); settle();
    expect_cyc("after_cmp", 2'b00, 5'h03, 1'b0);

    run_to_exec(5'b10000);
    expect_cyc("exec_nop", 2'b10, 5'h00, 1'b0);
    tick(); settle();
    expect_cyc("after_nop", 2'b00, 5'h03, 1'b0);

    run_to_exec(5'b00111);
    expect_cyc("exec_alu7", 2'b10, 5'h14, 1'b0);
    tick(); settle();

    run = 1'b0;
    settle();
    expect_cyc("stall_fetch", 2'b00, 5'h00, 1'b0);
    run = 1'b1;
    opcode = 5'b00000;
    tick(); settle();
    expect_cyc("resume_wait", 2'b01, 5'h00, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      expect_cyc("stall_wait", 2'b01, 5'h00, 1'b0);
    end
    run = 1'b1;
    settle();
    expect_cyc("resume_wait2", 2'b01, 5'h00, 1'b0);
    tick(); settle();
    expect_cyc("resume_exec", 2'b10, 5'h14, 1'b0);
    run = 1'b0;
    settle();
    expect_cyc("stall_exec", 2'b10, 5'h00, 1'b0);
    tick(); settle();
    expect_cyc("stall_exec_hold", 2'b10, 5'h00, 1'b0);
    run = 1'b1;
    tick(); settle();
    expect_cyc("post_stall_fetch", 2'b00, 5'h03, 1'b0);

    run_to_exec(5'b11111);
    expect_cyc("exec_halt", 2'b10, 5'h00, 1'b0);
    tick(); settle();
    expect_cyc("halted", 2'b11, 5'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      opcode = 5'(i * 3);
      tick(); settle();
      expect_cyc("halt_absorb", 2'b11, 5'h00, 1'b1);
    end

    rst_n = 1'b0;
    settle();
    expect_cyc("halt_rst_low", 2'b11, 5'h00, 1'b1);
    tick();
    rst_n = 1'b1;
    opcode = 5'b00000;
    settle();
    expect_cyc("halt_rst_exit", 2'b00, 5'h03, 1'b0);

    run_to_exec(5'b00000);
    expect_cyc("exec_before_rst", 2'b10, 5'h14, 1'b0);
    rst_n = 1'b0;
    settle();
    expect_cyc("exec_rst_low", 2'b10, 5'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    settle();
    expect_cyc("exec_rst_fetch", 2'b00, 5'h03, 1'b0);

    tick(); settle();
    run = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    expect_cyc("rst_over_run", 2'b00, 5'h00, 1'b0);
    run = 1'b1;
    settle();
    expect_cyc("rst_over_run_go", 2'b00, 5'h03, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
